depacketizer_2: RTL and testbench

Reassembles two-flit NoC packets, one flit per cycle, back into a single data word with its destination field. This is the receive-side counterpart of the two-flit packetizer and sits between a NoC fabric port and a user module input. It handles flits carried over a flit-serial link. It tracks head/tail framing, registers the rebuilt word behind a valid/ready handshake, and flags malformed framing.

---
 rtl/depacketizer_2_pkg.sv | 31 +++
 rtl/depacketizer_2_out_reg.sv | 37 +++
 rtl/depacketizer_2.sv | 143 ++++++++++++++
 tb/tb_depacketizer_2.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/depacketizer_2_pkg.sv
// Shared definitions for the two-flit packetizer/depacketizer pair:
// flit control-bit offsets, payload-width helpers and the receive FSM state.
package depacketizer_2_pkg;

   // Control bit offsets counted down from the flit MSB
   localparam int unsigned VALID_BIT = 0;
   localparam int unsigned HEAD_BIT  = 1;
   localparam int unsigned TAIL_BIT  = 2;
   localparam int unsigned CTRL_BITS = 3;

   function automatic int unsigned f1_width(input int unsigned flit_w,
                                            input int unsigned addr_w,
                                            input int unsigned vc_w);
      return flit_w - CTRL_BITS - addr_w - vc_w;
   endfunction

   function automatic int unsigned f2_width(input int unsigned flit_w,
                                            input int unsigned vc_w);
      return flit_w - CTRL_BITS - vc_w;
   endfunction

   function automatic bit single_flit(input int unsigned flit_w,
                                      input int unsigned addr_w,
                                      input int unsigned vc_w,
                                      input int unsigned width_out);
      return width_out <= f1_width(flit_w, addr_w, vc_w);
   endfunction

   typedef enum logic {IDLE, BODY} state_t;

endpackage

// File: rtl/depacketizer_2_out_reg.sv
// One-entry valid/ready output register holding the rebuilt word, dst and VC.
module depacketizer_out_reg #(
   parameter int unsigned DW = 12,
   parameter int unsigned AW = 4,
   parameter int unsigned VW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] data,
   input  logic [AW-1:0] dst,
   input  logic [VW-1:0] vc,
   input  logic          ready_in,
   output logic [DW-1:0] data_out,
   output logic [AW-1:0] dst_out,
   output logic [VW-1:0] vc_out,
   output logic          valid_out
);

   // A reload in the drain cycle keeps valid_out high with no bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         dst_out   <= '0;
         vc_out    <= '0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= data;
         dst_out   <= dst;
         vc_out    <= vc;
      end else if (ready_in) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: rtl/depacketizer_2.sv
// Receive side of the two-flit NoC link: rebuilds one data word from a
// head/tail flit pair, checks framing and presents it behind valid/ready.
module depacketizer_2
   import depacketizer_2_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH    = 4,
   parameter int unsigned VC_ADDRESS_WIDTH = 1,
   parameter int unsigned WIDTH_IN         = 36,
   parameter int unsigned WIDTH_OUT        = 12
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH_IN/2-1:0]       flit_in,
   output logic                        ready_out,
   output logic [WIDTH_OUT-1:0]        data_out,
   output logic [ADDRESS_WIDTH-1:0]    dst_out,
   output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        error_out
);

   localparam int unsigned FLIT_W = WIDTH_IN / 2;
   localparam int unsigned F1     = f1_width(FLIT_W, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
   localparam int unsigned F2     = f2_width(FLIT_W, VC_ADDRESS_WIDTH);
   localparam bit          SINGLE = single_flit(FLIT_W, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_OUT);
   localparam int unsigned H1     = SINGLE ? WIDTH_OUT : F1;
   localparam int unsigned REM    = SINGLE ? 0 : WIDTH_OUT - F1;

   if (WIDTH_OUT > F1 + F2) begin : g_width_check
      $error("depacketizer_2: WIDTH_OUT does not fit in two flits");
   end

   state_t state, state_nxt;

   logic                        f_valid, f_head, f_tail, accept;
   logic [VC_ADDRESS_WIDTH-1:0] f_vc;
   logic [ADDRESS_WIDTH-1:0]    f_dst;
   logic [H1-1:0]               f_head_pl;
   logic [H1-1:0]               hold_pl;
   logic [ADDRESS_WIDTH-1:0]    hold_dst;
   logic [VC_ADDRESS_WIDTH-1:0] hold_vc;
   logic [WIDTH_OUT-1:0]        body_word, head_word, ld_data;
   logic [ADDRESS_WIDTH-1:0]    ld_dst;
   logic [VC_ADDRESS_WIDTH-1:0] ld_vc;
   logic                        load_c, capture_c, err_c;
   logic                        unused_bits;

   // Flit field decode; padding and tail VC are intentionally dropped
   assign f_valid     = flit_in[FLIT_W-1-VALID_BIT];
   assign f_head      = flit_in[FLIT_W-1-HEAD_BIT];
   assign f_tail      = flit_in[FLIT_W-1-TAIL_BIT];
   assign f_vc        = flit_in[FLIT_W-1-CTRL_BITS -: VC_ADDRESS_WIDTH];
   assign f_dst       = flit_in[FLIT_W-1-CTRL_BITS-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
   assign f_head_pl   = flit_in[F1-1 -: H1];
   assign unused_bits = ^flit_in;

   assign ready_out = !valid_out | ready_in;
   assign accept    = f_valid & ready_out;

   if (SINGLE) begin : g_single
      assign body_word = hold_pl;
      assign head_word = f_head_pl;
   end else begin : g_dual
      assign body_word = {hold_pl, flit_in[F2-1 -: REM]};
      assign head_word = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = capture_c ? BODY : IDLE;
   end

   // Framing decode; a head seen in BODY restarts as if in IDLE
   always_comb begin
      load_c    = 1'b0;
      capture_c = 1'b0;
      err_c     = 1'b0;
      ld_data   = body_word;
      ld_dst    = hold_dst;
      ld_vc     = hold_vc;
      if (accept) begin
         if (state == BODY && !f_head) begin
            if (f_tail) load_c = 1'b1;
            else        err_c  = 1'b1;
         end else begin
            if (state == BODY) err_c = 1'b1;
            if (!f_head) begin
               err_c = 1'b1;
            end else if (!f_tail) begin
               capture_c = 1'b1;
            end else if (SINGLE) begin
               load_c  = 1'b1;
               ld_data = head_word;
               ld_dst  = f_dst;
               ld_vc   = f_vc;
            end else begin
               err_c = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_pl   <= '0;
         hold_dst  <= '0;
         hold_vc   <= '0;
         error_out <= 1'b0;
      end else begin
         error_out <= err_c;
         if (capture_c) begin
            hold_pl  <= f_head_pl;
            hold_dst <= f_dst;
            hold_vc  <= f_vc;
         end
      end
   end

   depacketizer_out_reg #(
      .DW(WIDTH_OUT),
      .AW(ADDRESS_WIDTH),
      .VW(VC_ADDRESS_WIDTH)
   ) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_c),
      .data     (ld_data),
      .dst      (ld_dst),
      .vc       (ld_vc),
      .ready_in (ready_in),
      .data_out (data_out),
      .dst_out  (dst_out),
      .vc_out   (vc_out),
      .valid_out(valid_out)
   );

endmodule

// File: tb/tb_depacketizer_2.sv
// Scoreboard bench for depacketizer_2: default 12-bit build plus an 8-bit
// single-flit build, driven with directed packets.
module tb_depacketizer_2;

   localparam int unsigned FW = 18;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [FW-1:0] flit_in, flit8;
   logic          ready_out, valid_out, ready_in, error_out;
   logic [11:0]   data_out;
   logic [3:0]    dst_out, dst8;
   logic [0:0]    vc_out, vc8;
   logic          ready_out8, valid8, ready_in8, error8;
   logic [7:0]    data8;

   typedef struct packed {logic [11:0] d; logic [3:0] dst; logic vc;} exp_t;
   typedef struct packed {logic [7:0] d; logic [3:0] dst; logic vc;} exp8_t;

   exp_t  exp_q[$];
   exp8_t exp8_q[$];
   int errors = 0, checks = 0;
   int err_pulses = 0, err8_pulses = 0, outs = 0, outs8 = 0;
   bit rnd_ready = 1'b0;

   always #5 clk = ~clk;

   depacketizer_2 dut (
      .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .ready_out(ready_out),
      .data_out(data_out), .dst_out(dst_out), .vc_out(vc_out),
      .valid_out(valid_out), .ready_in(ready_in), .error_out(error_out)
   );

   depacketizer_2 #(.WIDTH_OUT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .flit_in(flit8), .ready_out(ready_out8),
      .data_out(data8), .dst_out(dst8), .vc_out(vc8),
      .valid_out(valid8), .ready_in(ready_in8), .error_out(error8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Packetizer golden model
   function automatic logic [FW-1:0] mk_head(input logic [3:0] dst, input logic vc,
                                             input logic [9:0] pl, input logic tail);
      return {1'b1, 1'b1, tail, vc, dst, pl};
   endfunction

   function automatic logic [FW-1:0] mk_tail(input logic [1:0] pl, input logic vc);
      return {1'b1, 1'b0, 1'b1, vc, pl, 12'h000};
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (error_out) err_pulses++;
      if (valid_out && ready_in) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got data %0h, expected no output", data_out);
         end else begin
            e = exp_q.pop_front();
            check("data", 32'(data_out), 32'(e.d));
            check("dst", 32'(dst_out), 32'(e.dst));
            check("vc", 32'(vc_out), 32'(e.vc));
            outs++;
         end
      end
   end

   always @(negedge clk) begin : monitor8
      exp8_t e;
      if (error8) err8_pulses++;
      if (valid8 && ready_in8) begin
         if (exp8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output8: got data %0h, expected no output", data8);
         end else begin
            e = exp8_q.pop_front();
            check("data8", 32'(data8), 32'(e.d));
            check("dst8", 32'(dst8), 32'(e.dst));
            check("vc8", 32'(vc8), 32'(e.vc));
            outs8++;
         end
      end
   end

   initial begin : ready_gen
      ready_in = 1'b1;
      forever begin
         @(posedge clk); #1;
         ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic send(input logic [FW-1:0] f);
      flit_in = f;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ready_out) break;
      end
      if (!ready_out) begin
         checks++; errors++;
         $display("FAIL send_timeout: got ready_out=0, expected 1");
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      flit_in = '0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_pkt(input logic [11:0] d, input logic [3:0] dst, input logic vc);
      exp_q.push_back('{d: d, dst: dst, vc: vc});
      send(mk_head(dst, vc, d[11:2], 1'b0));
      send(mk_tail(d[1:0], ~vc));
   endtask

   task automatic wait_drain();
      flit_in = '0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && exp8_q.size() == 0 && !valid_out && !valid8) break;
      end
      check("drain_q", 32'(exp_q.size() + exp8_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   logic [11:0] b2b_d   [8] = '{12'h123, 12'hFFF, 12'h000, 12'h8A5, 12'h5A3, 12'h7E1, 12'hC0D, 12'h3B6};
   logic [3:0]  b2b_dst [8] = '{4'h0, 4'hF, 4'h3, 4'hA, 4'h6, 4'h9, 4'hC, 4'h1};

   initial begin : stim
      int e0, o0;
      flit_in = '0; flit8 = '0; ready_in8 = 1'b1; rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_error", 32'(error_out), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_dst", 32'(dst_out), 32'd0);
      check("rst_vc", 32'(vc_out), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd1);
      check("rst_valid8", 32'(valid8), 32'd0);
      @(posedge clk); #1;

      // Basic packet and one-cycle valid
      exp_q.push_back('{d: 12'hAAE, dst: 4'h5, vc: 1'b0});
      send(mk_head(4'h5, 1'b0, 10'h2AB, 1'b0));
      send(mk_tail(2'b10, 1'b1));
      flit_in = '0;
      @(negedge clk);
      check("t1_valid", 32'(valid_out), 32'd1);
      @(negedge clk);
      check("t1_valid_drop", 32'(valid_out), 32'd0);
      @(posedge clk); #1;

      // Back-to-back with random backpressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_pkt(b2b_d[i], b2b_dst[i], 1'(i));
      wait_drain();
      rnd_ready = 1'b0;
      idle(2);

      // Head, head, tail
      e0 = err_pulses; o0 = outs;
      exp_q.push_back('{d: 12'h5A6, dst: 4'h2, vc: 1'b1});
      send(mk_head(4'h1, 1'b0, 10'h3FF, 1'b0));
      send(mk_head(4'h2, 1'b1, 10'h169, 1'b0));
      send(mk_tail(2'b10, 1'b0));
      wait_drain();
      idle(2);
      check("hht_err", 32'(err_pulses - e0), 32'd1);
      check("hht_outs", 32'(outs - o0), 32'd1);

      // Lone tail, head+non-tail body, head with tail set on a dual build
      e0 = err_pulses; o0 = outs;
      send(mk_tail(2'b11, 1'b0));
      idle(3);
      check("lone_tail_err", 32'(err_pulses - e0), 32'd1);
      check("lone_tail_outs", 32'(outs - o0), 32'd0);
      send(mk_head(4'h4, 1'b0, 10'h0F0, 1'b0));
      send({3'b100, 1'b0, 2'b11, 12'h000});
      idle(2);
      send(mk_head(4'h4, 1'b0, 10'h0F0, 1'b1));
      idle(3);
      check("bad_frame_err", 32'(err_pulses - e0), 32'd3);
      send_pkt(12'h9D1, 4'hE, 1'b1);
      wait_drain();
      idle(2);
      check("recover_err", 32'(err_pulses - e0), 32'd3);
      check("recover_outs", 32'(outs - o0), 32'd1);

      // Reset between head and tail
      send(mk_head(4'h7, 1'b1, 10'h155, 1'b0));
      flit_in = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(valid_out), 32'd0);
      check("mid_rst_data", 32'(data_out), 32'd0);
      check("mid_rst_dst", 32'(dst_out), 32'd0);
      check("mid_rst_vc", 32'(vc_out), 32'd0);
      @(posedge clk); #1;
      e0 = err_pulses; o0 = outs;
      send(mk_tail(2'b01, 1'b0));
      idle(2);
      check("post_rst_tail_err", 32'(err_pulses - e0), 32'd1);
      send_pkt(12'h3C7, 4'h9, 1'b0);
      wait_drain();
      check("post_rst_outs", 32'(outs - o0), 32'd1);

      // Single-flit build accepts one packet per cycle
      exp8_q.push_back('{d: 8'hC3, dst: 4'h6, vc: 1'b1});
      exp8_q.push_back('{d: 8'h5A, dst: 4'hB, vc: 1'b0});
      exp8_q.push_back('{d: 8'hFF, dst: 4'h0, vc: 1'b1});
      flit8 = {3'b111, 1'b1, 4'h6, 8'hC3, 2'b00};
      @(negedge clk);
      check("s8_ready0", 32'(ready_out8), 32'd1);
      check("s8_valid0", 32'(valid8), 32'd0);
      @(posedge clk); #1;
      flit8 = {3'b111, 1'b0, 4'hB, 8'h5A, 2'b11};
      @(negedge clk);
      check("s8_valid1", 32'(valid8), 32'd1);
      check("s8_ready1", 32'(ready_out8), 32'd1);
      @(posedge clk); #1;
      flit8 = {3'b111, 1'b1, 4'h0, 8'hFF, 2'b00};
      @(negedge clk);
      check("s8_valid2", 32'(valid8), 32'd1);
      @(posedge clk); #1;
      flit8 = '0;
      wait_drain();
      check("s8_outs", 32'(outs8), 32'd3);
      check("s8_err", 32'(err8_pulses), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
